// File: rtl/muldiv.sv
// muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit holding HI/LO (MTHI/MTLO via hi_we/lo_we/wdata).
// Ports: start/op/rs/rt issue, busy/done handshake, hi/lo results. Option: MULDIV_FAST_MUL_EN.
module muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic              sa;
  logic              sb;
  logic              dz;
  logic [XLEN-1:0]   m;
  logic [2*XLEN-1:0] acc;
  logic [5:0]        cnt;

  logic              sgn;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;

  // m is the addend (|rs|) for multiply, the divisor (|rt|) for divide.
  // acc low half starts as the multiplier or the dividend.
  always_comb begin
    sgn   = ~op[0];
    abs_a = (sgn && rs[XLEN-1]) ? -rs : rs;
    abs_b = (sgn && rt[XLEN-1]) ? -rt : rt;
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, m};
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_sh - {1'b0, m};
    div_ge   = (div_sh >= {1'b0, m});
    if (op_q[1]) begin
      if (div_ge)
        step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        step = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      step = acc[0] ? {mul_sum, acc[XLEN-1:1]}
                    : {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1:1]};
    end
  end

  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod = acc;
`else
    prod = (sa ^ sb) ? -acc : acc;
`endif
    quo = acc[XLEN-1:0];
    rem = acc[2*XLEN-1:XLEN];
    if (op_q[1]) begin
      res_lo = dz ? '1 : ((sa ^ sb) ? -quo : quo);
      res_hi = sa ? -rem : rem;
    end else begin
      res_lo = prod[XLEN-1:0];
      res_hi = prod[2*XLEN-1:XLEN];
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] ext_a;
  logic [2*XLEN-1:0] ext_b;
  logic [2*XLEN-1:0] fast_prod;

  // Low 2*XLEN bits of the product of extended operands equal
  // the signed or unsigned product.
  always_comb begin
    ext_a     = {{XLEN{sgn & rs[XLEN-1]}}, rs};
    ext_b     = {{XLEN{sgn & rt[XLEN-1]}}, rt};
    fast_prod = ext_a * ext_b;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      dz    <= 1'b0;
      m     <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            sa    <= sgn & rs[XLEN-1];
            sb    <= sgn & rt[XLEN-1];
            dz    <= (rt == '0);
            m     <= op[1] ? abs_b : abs_a;
            acc   <= {{XLEN{1'b0}}, op[1] ? abs_a : abs_b};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
`ifdef MULDIV_FAST_MUL_EN
            if (!op[1]) begin
              acc   <= fast_prod;
              state <= FIX;
            end
`endif
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          acc <= step;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: randomized and directed checks of muldiv against
// an arithmetic reference model.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs(rs), .rt(rt), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_model(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa_v = longint'($signed(a));
    longint sb_v = longint'($signed(b));
    longint q;
    longint r;
    logic [63:0] res;
    case (o)
      2'd0: res = 64'(sa_v * sb_v);
      2'd1: res = {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa_v / sb_v;
          r = sa_v % sb_v;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit stray,
                        input bit busy_wr);
    logic [63:0] exp;
    logic [63:0] old;
    int n;
    int lat;
    bit seen;
    exp = ref_model(o, a, b);
    lat = 33;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) lat = 1;
`endif
    old = {hi, lo};
    start = 1'b1;
    op = o;
    rs = a;
    rt = b;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom);
    rs = $urandom;
    rt = $urandom;
    check("accept_busy", 64'(busy), 64'd1);
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      start = (stray && (n == 5 || n == 20));
      if (busy_wr && n == 10) begin
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1234;
      end else begin
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
      else check("hold_hilo", {hi, lo}, old);
    end
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("latency", 64'(n), 64'(lat));
    check("busy_done_at_done", {62'b0, busy, done}, 64'd1);
    check("result", {hi, lo}, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'd0;
    rs = 32'd0;
    rt = 32'd0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = 32'd0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    hi_we = 1'b1;
    wdata = 32'h1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi_idle", {hi, lo}, {32'h1234, 32'h0});
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hA5A5_0F0F;
    @(posedge clk); #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthi_mtlo_both", {hi, lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});

    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    check("multu_max_const", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});
    run_op(2'd0, 32'hFFFFFFFD, 32'd5, 0, 0);
    check("mult_neg_const", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFF1});
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 0, 0);
    check("div_neg_const", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("div_ovf_const", {hi, lo}, {32'h0, 32'h80000000});
    run_op(2'd3, 32'd5, 32'd0, 0, 0);
    check("divu_zero_const", {hi, lo}, {32'd5, 32'hFFFFFFFF});
    run_op(2'd2, 32'hFFFFFF00, 32'd0, 0, 0);
    run_op(2'd3, 32'd100, 32'd7, 1, 0);
    check("divu_stray_const", {hi, lo}, {32'd2, 32'd14});
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check("no_extra_done", {62'b0, busy, done}, 64'd0);
    end
    run_op(2'd2, 32'd1000, 32'd3, 0, 1);
    check("write_while_busy", 64'(hi), 64'd1);

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom), pick(), pick(), 0, 0);

    start = 1'b1;
    op = 2'd2;
    rs = 32'd12345;
    rt = 32'd17;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check("post_abort_idle", {busy, done, hi, lo}, 66'd0);
    end
    run_op(2'd1, 32'h0001_0000, 32'h0001_0000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv.md
# muldiv

Multi-cycle multiply/divide unit for the CPU execute stage, next to the single-cycle ALU.
- Executes MULT, MULTU, DIV and DIVU.
- Holds the architectural HI/LO registers, including MTHI/MTLO writes and MFHI/MFLO reads.
- Uses an iterative datapath with a start/busy/done handshake; the pipeline stalls on `busy`.

## Interface
Parameters:
- `XLEN`, 32: operand width. Only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request; sampled on `clk` edges.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs`  in  32  operand A: multiplicand or dividend.
- `rt`  in  32  operand B: multiplier or divisor.
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `hi`  out  32  HI register: product high half or remainder.
- `lo`  out  32  LO register: product low half or quotient.

## Operation
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0; state=IDLE; counter=0.
- States are IDLE, CALC and FIX.
- IDLE:
  - `start`=1 captures `op` and the sign flags.
  - For signed ops, captures |rs| and |rt| into working registers; otherwise raw values.
  - Clears the 6-bit counter and moves to CALC.
- CALC, multiply:
  - One shift-add step per cycle on a 64-bit accumulator.
  - Each step examines one multiplier bit, LSB first.
- CALC, divide:
  - One restoring step per cycle: shift the remainder left, bring in the next dividend bit MSB first.
  - Subtract the divisor when remainder ≥ divisor; the quotient bit is 1 on subtraction.
- CALC always runs 32 steps, counter 0..31; no early termination. At counter 31 it moves to FIX.
- FIX sign correction:
  - Signed multiply: negate the 64-bit product if rs[31]^rt[31].
  - Signed divide: negate the quotient if rs[31]^rt[31]; negate the remainder if rs[31].
- FIX writes HI/LO, pulses `done`, returns to IDLE.
- All arithmetic is modulo 2^32 per half. DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, with no trap.
- Divide by zero (rt=0, DIV or DIVU):
  - Still takes the full latency.
  - Result is HI=rs (original value), LO=0xFFFFFFFF.
- MTHI/MTLO:
  - `hi_we`/`lo_we` in IDLE with `start`=0 write `wdata` on the edge.
  - Both may be asserted together.
  - Ignored while `busy`=1 or when `start`=1 in the same cycle, since the pipeline never issues both.
- `start` while `busy`=1 is ignored; it is neither queued nor does it corrupt the operation.
- `hi`/`lo` keep their old values throughout CALC.

## Timing
- Edge 0: `start` accepted; `busy`=1 after edge 0.
- Edges 1..32: CALC steps.
- Edge 33 (FIX):
  - HI/LO are updated.
  - `done`=1 for the cycle after edge 33.
  - `busy`=0 after edge 33.
- Latency is 33 cycles from the accepting edge to the visible result.
- A new `start` can be presented in the `done` cycle and is accepted at edge 34, giving back-to-back issue with no bubble beyond `done`.
- `done` and `busy` are never high together.
- Asynchronous `rst_n`=0 mid-operation:
  - Aborts immediately; all outputs go to their reset values.
  - No partial result is written.
  - After release, the unit is in IDLE.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single registered 64-bit multiplier: IDLE→FIX directly.
  - Edge 0 accepts; HI/LO and `done` follow edge 1; `busy` is high for exactly one cycle.
  - Signed multiply uses a native signed product, so no FIX negation.
  - DIV/DIVU are unchanged at 33 cycles.
- Undefined: all four ops use the iterative 33-cycle path; no hardware multiplier is inferred.

## Test plan
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001, `done` one cycle after edge 33 (edge 1 with `MULDIV_FAST_MUL_EN`).
- MULT rs=0xFFFFFFFD (-3) rt=5: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV rs=0xFFFFFFF9 (-7) rt=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU rs=5 rt=0: HI=5, LO=0xFFFFFFFF after 33 cycles.
- DIVU 100/7 with extra `start` pulses at cycles 5 and 20: result LO=14, HI=2, and exactly one `done`.
- `hi_we`=1 `wdata`=0x1234 while busy: HI unchanged.
- Same write in IDLE: HI=0x1234 next cycle.
- `rst_n` pulsed low at cycle 10 of DIV: `busy`/`hi`/`lo`/`done` go to 0 immediately and no `done` ever appears.
